// File: rtl/sev_seg_mux_driver_if.sv
// Display-side bundle for sev_seg_mux_driver: value load/masks in, segment/anode pins out.
interface sev_seg_mux_driver_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] values;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    blink_led;
  logic                    commit;

  modport master (
    output load, values, digit_en, blink_mask,
    input  seg_n, an_n, blink_led, commit
  );

  modport slave (
    input  load, values, digit_en, blink_mask,
    output seg_n, an_n, blink_led, commit
  );
endinterface

// File: rtl/sev_seg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered values, dead time and blink.
// Define SEVSEG_LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module sev_seg_mux_driver #(
  parameter int NUM_DIGITS        = 2,
  parameter int DWELL_CYCLES      = 24000,
  parameter int DEAD_CYCLES       = 240,
  parameter int BLINK_HALF_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  sev_seg_mux_driver_if.slave  bus
);
  localparam int DC_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int DI_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BC_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DWELL_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_DEAD = DC_W'(DEAD_CYCLES);
  localparam logic [DI_W-1:0] DI_LAST = DI_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_HALF_CYCLES - 1);

  logic [DC_W-1:0]         dc_q, dc_d;
  logic [DI_W-1:0]         di_q, di_d;
  logic [BC_W-1:0]         bc_q, bc_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_v_q, pend_v_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    commit_q, commit_d;
  logic                    slot_end, frame_end;
  logic [NUM_DIGITS-1:0]   lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Scan/blink counters and the pending->display handoff at frame end
  always_comb begin
    slot_end  = (dc_q == DC_LAST);
    frame_end = slot_end && (di_q == DI_LAST);
    dc_d      = slot_end ? '0 : dc_q + DC_W'(1);
    di_d      = di_q;
    if (slot_end) di_d = (di_q == DI_LAST) ? '0 : di_q + DI_W'(1);
    bc_d      = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);
    phase_d   = (bc_q == BC_LAST) ? ~phase_q : phase_q;
    commit_d  = frame_end && pend_v_q;
    disp_d    = commit_d ? pend_q : disp_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    // A load on the frame-end cycle keeps pend_v set so the new value waits a full frame
    if (bus.load) begin
      pend_d   = bus.values;
      pend_v_d = 1'b1;
    end else if (frame_end) begin
      pend_v_d = 1'b0;
    end
  end

  always_comb begin
    lz_blank = '0;
`ifdef SEVSEG_LEAD_ZERO_BLANK_EN
    begin
      logic all_zero;
      all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        all_zero    = all_zero && (disp_q[4*k +: 4] == 4'h0);
        lz_blank[k] = all_zero;
      end
    end
`endif
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((di_q == DI_W'(k)) && (dc_q >= DC_DEAD) && bus.digit_en[k] &&
          !(bus.blink_mask[k] && !phase_q) && !lz_blank[k]) begin
        an_d[k] = 1'b0;
        seg_d   = hex7(disp_q[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_q     <= '0;
      di_q     <= '0;
      bc_q     <= '0;
      phase_q  <= 1'b0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      commit_q <= 1'b0;
    end else begin
      dc_q     <= dc_d;
      di_q     <= di_d;
      bc_q     <= bc_d;
      phase_q  <= phase_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      commit_q <= commit_d;
    end
  end

  assign bus.seg_n     = seg_q;
  assign bus.an_n      = an_q;
  assign bus.blink_led = phase_q;
  assign bus.commit    = commit_q;
endmodule

// File: doc/sev_seg_mux_driver.md
# sev_seg_mux_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It displays NUM_DIGITS hex nibbles with tear-free double-buffered updates, per-digit enable and blink masks, and anti-ghosting dead time. It also generates the board status blink LED. It sits between the switch/datapath logic and the display pins, replacing single-digit combinational decode at the top level.

## Interface

- NUM_DIGITS, 2: number of multiplexed digits, 1..8.
- DWELL_CYCLES, 24000: clk cycles each digit slot lasts (1 ms at 24 MHz); must be ≥ DEAD_CYCLES+1.
- DEAD_CYCLES, 240: cycles at the start of each slot with all anodes off.
- BLINK_HALF_CYCLES, 5000000: half-period of the blink phase (2.4 Hz at 24 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures `values` into the pending buffer.
- values  in  4*NUM_DIGITS  hex nibbles; digit k is `values[4k+3:4k]`; digit 0 is least significant.
- digit_en  in  NUM_DIGITS  live per-digit enable; 0 blanks the digit.
- blink_mask  in  NUM_DIGITS  live per-digit blink select.
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- an_n  out  NUM_DIGITS  active-low digit anodes; at most one bit is low.
- blink_led  out  1  blink phase, driven directly to an LED.
- commit  out  1  one-cycle pulse when pending data becomes displayed.

## Operation

- State:
  - dwell counter `dc` counts 0..DWELL_CYCLES-1.
  - digit index `di` counts 0..NUM_DIGITS-1.
  - blink counter and blink phase register.
  - display buffer, pending buffer, and a `pend_v` flag.
- Slot advance: when `dc`=DWELL_CYCLES-1, `dc`←0 and `di`←(`di`+1) mod NUM_DIGITS.
- Frame end: the cycle where `di`=NUM_DIGITS-1 and `dc`=DWELL_CYCLES-1.
- Load:
  - `load`=1 → pending←`values` and `pend_v`←1.
  - A later load before commit overwrites pending; the latest load wins.
- Commit:
  - At frame end with `pend_v`=1 → display←pending, `pend_v`←0, and `commit`=1 on the next cycle.
  - If `load` and frame end coincide, the old pending value commits. The new value becomes pending with `pend_v`=1 and commits at the following frame end.
- Output decode, evaluated from state and live masks:
  - If `dc` < DEAD_CYCLES, or `digit_en[di]`=0, or (`blink_mask[di]`=1 and blink phase=0), or digit `di` is leading-blanked (see Configuration): `an_n`=all 1s and `seg_n`=7'b1111111.
  - Otherwise `an_n[di]`=0 and `seg_n`=hex decode of display nibble `di`.
- Hex decode (active-low):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- Blink: the blink counter wraps at BLINK_HALF_CYCLES-1 and toggles the phase on wrap. `blink_led` equals the phase.

## Timing

- Reset values, all applied asynchronously:
  - `dc`=0, `di`=0, blink counter=0, phase=0, display=0, pending=0, `pend_v`=0.
  - `seg_n`=7'h7F, `an_n`=all 1s, `blink_led`=0, `commit`=0.
- Latency: `seg_n`, `an_n` and `commit` are registered, so they reflect the previous cycle's state. `blink_led` is the phase register itself.
- Dead time: the first DEAD_CYCLES output cycles of every slot have all anodes off. Consecutive digits are therefore never driven back-to-back.
- Changes to `digit_en` and `blink_mask` appear on the outputs one cycle later. Changes to `values` without `load` have no effect.
- Reset asserted mid-frame discards pending data and restarts at slot 0, `dc`=0.

## Configuration

- SEVSEG_LEAD_ZERO_BLANK_EN
  - Defined: digit k (k ≥ 1) is blanked when display nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never leading-blanked.
  - Undefined: no leading-zero blanking; all enabled digits are shown.

## Test plan

All scenarios use NUM_DIGITS=4, DWELL_CYCLES=8, DEAD_CYCLES=2, BLINK_HALF_CYCLES=64.

- Reset, then idle: `seg_n`=7F and `an_n`=F for the first 2 cycles of each slot. Afterwards slot k shows `an_n` with bit k low and `seg_n`=1000000. Frame is 32 cycles.
- `load` with `values`=16'h3A0F mid-frame 0: no change until frame end, `commit` pulses once, next frame digits show F,0,A,3 (0001110, 1000000, 0001000, 0110000).
- Two loads in one frame (1111 then 2222): only 2222 is committed, with a single `commit` pulse. `load` on a frame-end cycle defers by exactly one frame.
- `blink_mask`=4'b0010: digit 1 is dark for 64 cycles, then lit for 64 cycles, in step with `blink_led` toggling every 64 cycles. `digit_en`=4'b1011 keeps digit 2 always dark.
- Macro defined, `values`=16'h0005 committed: digits 1–3 have `an_n` stay high and digit 0 shows 0010010. Macro undefined: all four digits are lit.
- Reset asserted mid-slot 2 with `pend_v`=1: outputs go to reset values immediately, no `commit` follows, and display restarts at slot 0.
